// File: rtl/am_err_pkg.sv
// Shared types, default widths and width helpers for the am_err_* error-characterisation blocks.
package am_err_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } am_err_state_e;

    localparam int unsigned W_DEF     = 8;
    localparam int unsigned LOG_N_DEF = 16;

    localparam int unsigned PROD_W = 2 * W_DEF;
    localparam int unsigned SUM_W  = 2 * W_DEF + LOG_N_DEF;
    localparam int unsigned SSUM_W = 2 * W_DEF + LOG_N_DEF + 1;
    localparam int unsigned CNT_W  = LOG_N_DEF + 1;

    function automatic int unsigned prod_w(input int unsigned w);
        return 2 * w;
    endfunction

    function automatic int unsigned sum_w(input int unsigned w, input int unsigned log_n);
        return 2 * w + log_n;
    endfunction

    function automatic int unsigned ssum_w(input int unsigned w, input int unsigned log_n);
        return 2 * w + log_n + 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned log_n);
        return log_n + 1;
    endfunction

endpackage

// File: rtl/am_err_diff.sv
// Combinational error term between an exact and an approximate product:
// signed difference z - exact, its magnitude, and a nonzero flag.
module am_err_diff #(
    parameter int unsigned PW = 16
) (
    input  logic [PW-1:0]   exact_i,
    input  logic [PW-1:0]   z_i,
    output logic signed [PW:0] d_o,
    output logic [PW-1:0]   ed_o,
    output logic            nz_o
);

    logic [PW:0] neg_d;

    // One extra bit keeps the full range of z - exact without wrap.
    assign d_o   = $signed({1'b0, z_i} - {1'b0, exact_i});
    assign neg_d = -d_o;
    assign ed_o  = d_o[PW] ? neg_d[PW-1:0] : d_o[PW-1:0];
    assign nz_o  = |ed_o;

endmodule

// File: rtl/am_err_stats.sv
// Windowed error statistics for an 8x8 approximate multiplier under test.
// Optional AM_ERR_SQ_EN adds a sum of squared error distances (sum_sq_o) for MSE.
module am_err_stats
    import am_err_pkg::*;
#(
    parameter int unsigned LOG_N = LOG_N_DEF,
    parameter int unsigned W     = W_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic                   clr_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [W-1:0]           x_i,
    input  logic [W-1:0]           y_i,
    input  logic [2*W-1:0]         z_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [2*W+LOG_N-1:0]   sum_ed_o,
    output logic [2*W+LOG_N:0]     sum_sed_o,
    output logic [2*W-1:0]         max_ed_o,
    output logic [LOG_N:0]         err_cnt_o,
`ifdef AM_ERR_SQ_EN
    output logic [4*W+LOG_N-1:0]   sum_sq_o,
`endif
    output logic                   busy_o
);

    localparam int unsigned ProdW  = prod_w(W);
    localparam int unsigned SumW   = sum_w(W, LOG_N);
    localparam int unsigned SsumW  = ssum_w(W, LOG_N);
    localparam int unsigned CntW   = cnt_w(LOG_N);
    localparam int unsigned ExtW   = SsumW - ProdW - 1;
    localparam logic [CntW-1:0] LastCnt = CntW'((2 ** LOG_N) - 1);

    am_err_state_e state_q, state_d;

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             v1_q, v1_d;
    logic [ProdW-1:0] exact_q, exact_d;
    logic [ProdW-1:0] zr_q, zr_d;

    logic [SumW-1:0]  sum_ed_q, sum_ed_d;
    logic [SsumW-1:0] sum_sed_q, sum_sed_d;
    logic [ProdW-1:0] max_ed_q, max_ed_d;
    logic [CntW-1:0]  err_cnt_q, err_cnt_d;

    logic signed [ProdW:0] d;
    logic [ProdW-1:0]      ed;
    logic                  nz;

    logic fire;
    logic s2_en;
    logic clear_acc;

`ifdef AM_ERR_SQ_EN
    localparam int unsigned SqW = 4 * W + LOG_N;

    logic [SqW-1:0]     sum_sq_q, sum_sq_d;
    logic [2*ProdW-1:0] ed_ext;
    logic [2*ProdW-1:0] ed_sq;

    assign ed_ext = {{ProdW{1'b0}}, ed};
    assign ed_sq  = ed_ext * ed_ext;
`endif

    am_err_diff #(
        .PW (ProdW)
    ) u_diff (
        .exact_i (exact_q),
        .z_i     (zr_q),
        .d_o     (d),
        .ed_o    (ed),
        .nz_o    (nz)
    );

    assign in_ready_o  = (state_q == StRun);
    assign out_valid_o = (state_q == StDone);
    assign busy_o      = (state_q == StRun) || (state_q == StDrain);

    // clr wins over an accept or an S2 update in the same cycle.
    assign fire  = in_valid_i & in_ready_o & ~clr_i;
    assign s2_en = v1_q & ~clr_i;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        v1_d      = fire;
        exact_d   = exact_q;
        zr_d      = zr_q;
        sum_ed_d  = sum_ed_q;
        sum_sed_d = sum_sed_q;
        max_ed_d  = max_ed_q;
        err_cnt_d = err_cnt_q;
`ifdef AM_ERR_SQ_EN
        sum_sq_d  = sum_sq_q;
`endif
        clear_acc = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d   = StRun;
                    clear_acc = 1'b1;
                end
            end
            StRun: begin
                if (fire && (cnt_q == LastCnt)) state_d = StDrain;
            end
            // Last sample has left S1 once v1 is low; its S2 update is then done.
            StDrain: begin
                if (!v1_q) state_d = StDone;
            end
            StDone: begin
                if (out_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (fire) begin
            cnt_d   = cnt_q + CntW'(1);
            exact_d = ProdW'(x_i) * ProdW'(y_i);
            zr_d    = z_i;
        end

        if (s2_en) begin
            sum_ed_d  = sum_ed_q + SumW'(ed);
            sum_sed_d = sum_sed_q + {{ExtW{d[ProdW]}}, d};
            err_cnt_d = err_cnt_q + CntW'(nz);
            if (ed > max_ed_q) max_ed_d = ed;
`ifdef AM_ERR_SQ_EN
            sum_sq_d  = sum_sq_q + SqW'(ed_sq);
`endif
        end

        if (clear_acc) begin
            cnt_d     = '0;
            sum_ed_d  = '0;
            sum_sed_d = '0;
            max_ed_d  = '0;
            err_cnt_d = '0;
`ifdef AM_ERR_SQ_EN
            sum_sq_d  = '0;
`endif
        end

        if (clr_i) begin
            state_d = StIdle;
            v1_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            v1_q      <= 1'b0;
            exact_q   <= '0;
            zr_q      <= '0;
            sum_ed_q  <= '0;
            sum_sed_q <= '0;
            max_ed_q  <= '0;
            err_cnt_q <= '0;
`ifdef AM_ERR_SQ_EN
            sum_sq_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            v1_q      <= v1_d;
            exact_q   <= exact_d;
            zr_q      <= zr_d;
            sum_ed_q  <= sum_ed_d;
            sum_sed_q <= sum_sed_d;
            max_ed_q  <= max_ed_d;
            err_cnt_q <= err_cnt_d;
`ifdef AM_ERR_SQ_EN
            sum_sq_q  <= sum_sq_d;
`endif
        end
    end

    assign sum_ed_o  = sum_ed_q;
    assign sum_sed_o = sum_sed_q;
    assign max_ed_o  = max_ed_q;
    assign err_cnt_o = err_cnt_q;
`ifdef AM_ERR_SQ_EN
    assign sum_sq_o  = sum_sq_q;
`endif

endmodule

// File: tb/tb_am_err_stats.sv
// Scoreboard bench for am_err_stats: a LOG_N=2 instance for directed windows and a
// LOG_N=16 instance for the exhaustive exact-product sweep.
module tb_am_err_stats;

    typedef struct {
        logic signed [63:0] ed;
        logic signed [63:0] sed;
        logic signed [63:0] mx;
        logic signed [63:0] cnt;
        logic signed [63:0] sq;
    } res_t;

    int checks = 0;
    int passed = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Small instance (LOG_N = 2)
    logic        rst_n = 1'b1, start = 1'b0, clr = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0]  x = '0, y = '0;
    logic [15:0] z = '0;
    logic        in_ready, out_valid, busy;
    logic [17:0] sum_ed;
    logic [18:0] sum_sed;
    logic [15:0] max_ed;
    logic [2:0]  err_cnt;
`ifdef AM_ERR_SQ_EN
    logic [33:0] sum_sq;
`endif

    // Exhaustive instance (LOG_N = 16)
    logic        rst_n16 = 1'b1, start16 = 1'b0, in_valid16 = 1'b0, out_ready16 = 1'b0;
    logic [7:0]  x16 = '0, y16 = '0;
    logic [15:0] z16 = '0;
    logic        in_ready16, out_valid16, busy16;
    logic [31:0] sum_ed16;
    logic [32:0] sum_sed16;
    logic [15:0] max_ed16;
    logic [16:0] err_cnt16;
`ifdef AM_ERR_SQ_EN
    logic [47:0] sum_sq16;
`endif

    am_err_stats #(.LOG_N(2), .W(8)) u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .clr_i       (clr),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .x_i         (x),
        .y_i         (y),
        .z_i         (z),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .sum_ed_o    (sum_ed),
        .sum_sed_o   (sum_sed),
        .max_ed_o    (max_ed),
        .err_cnt_o   (err_cnt),
`ifdef AM_ERR_SQ_EN
        .sum_sq_o    (sum_sq),
`endif
        .busy_o      (busy)
    );

    am_err_stats #(.LOG_N(16), .W(8)) u_dut16 (
        .clk_i       (clk),
        .rst_ni      (rst_n16),
        .start_i     (start16),
        .clr_i       (1'b0),
        .in_valid_i  (in_valid16),
        .in_ready_o  (in_ready16),
        .x_i         (x16),
        .y_i         (y16),
        .z_i         (z16),
        .out_valid_o (out_valid16),
        .out_ready_i (out_ready16),
        .sum_ed_o    (sum_ed16),
        .sum_sed_o   (sum_sed16),
        .max_ed_o    (max_ed16),
        .err_cnt_o   (err_cnt16),
`ifdef AM_ERR_SQ_EN
        .sum_sq_o    (sum_sq16),
`endif
        .busy_o      (busy16)
    );

    // Directed vectors: set A = known errors, set B = large/negative errors.
    int ax[4] = '{3, 10, 255, 0};
    int ay[4] = '{5, 10, 255, 7};
    int az[4] = '{14, 104, 65025, 0};
    int bx[4] = '{255, 1, 200, 16};
    int by[4] = '{255, 1, 3, 16};
    int bz[4] = '{0, 2, 600, 250};
    int no_gaps[4]    = '{0, 0, 0, 0};
    int burst_gaps[4] = '{2, 0, 3, 1};

    res_t exp_q[$];
    res_t exp16_q[$];

    int acc_cnt = 0;
    int busy_err = 0;
    logic track_busy = 1'b0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic res_t res_a();
        res_t r;
        r.ed = 5; r.sed = 3; r.mx = 4; r.cnt = 2; r.sq = 17;
        return r;
    endfunction

    function automatic res_t res_b();
        res_t r;
        r.ed = 65032; r.sed = -65030; r.mx = 65025; r.cnt = 3; r.sq = 64'd4228250662;
        return r;
    endfunction

    // Accepts counted before the DUT's state update at the same edge.
    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready && !clr) acc_cnt++;
        if (track_busy && !busy && !out_valid) busy_err++;
    end

    logic ov_prev = 1'b0;
    always @(negedge clk) begin
        res_t e;
        if (!rst_n) begin
            ov_prev = 1'b0;
        end else begin
            if (out_valid && !ov_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sum_ed", 64'(sum_ed), e.ed);
                    check("sum_sed", 64'($signed(sum_sed)), e.sed);
                    check("max_ed", 64'(max_ed), e.mx);
                    check("err_cnt", 64'(err_cnt), e.cnt);
`ifdef AM_ERR_SQ_EN
                    check("sum_sq", 64'(sum_sq), e.sq);
`endif
                end
            end
            ov_prev = out_valid;
        end
    end

    logic ov16_prev = 1'b0;
    always @(negedge clk) begin
        res_t e;
        if (rst_n16) begin
            if (out_valid16 && !ov16_prev) begin
                if (exp16_q.size() == 0) begin
                    check("unexpected_out_valid16", 1, 0);
                end else begin
                    e = exp16_q.pop_front();
                    check("sweep_sum_ed", 64'(sum_ed16), e.ed);
                    check("sweep_sum_sed", 64'($signed(sum_sed16)), e.sed);
                    check("sweep_max_ed", 64'(max_ed16), e.mx);
                    check("sweep_err_cnt", 64'(err_cnt16), e.cnt);
`ifdef AM_ERR_SQ_EN
                    check("sweep_sum_sq", 64'(sum_sq16), e.sq);
`endif
                end
            end
            ov16_prev = out_valid16;
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Leaves in_valid high on return so the next call can issue back-to-back.
    task automatic send(input int sx, input int sy, input int sz, input int gap);
        int n = 0;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        in_valid = 1'b1;
        x = 8'(sx); y = 8'(sy); z = 16'(sz);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_ready_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic send_set(input logic use_b, input int gaps[4], input int count);
        for (int i = 0; i < count; i++) begin
            if (use_b) send(bx[i], by[i], bz[i], gaps[i]);
            else       send(ax[i], ay[i], az[i], gaps[i]);
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(out_valid), 1);
    endtask

    task automatic handshake(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check(name, 64'(out_valid), 0);
    endtask

    task automatic run_small();
        // Known errors, back-to-back, with exact latency and backpressure
        exp_q.push_back(res_a());
        do_start();
        send_set(1'b0, no_gaps, 4);
        in_valid = 1'b0;
        check("lat_accept", 64'(out_valid), 0);
        check("drain_in_ready", 64'(in_ready), 0);
        @(negedge clk);
        check("lat_plus1", 64'(out_valid), 0);
        @(negedge clk);
        check("lat_plus2", 64'(out_valid), 1);
        check("done_busy", 64'(busy), 0);
        for (int i = 0; i < 10; i++) begin
            start = (i >= 3 && i < 6);
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 1);
            check("bp_sum_ed", 64'(sum_ed), 5);
        end
        start = 1'b0;
        handshake("hs_a");
        check("hold_sum_ed", 64'(sum_ed), 5);
        check("hold_err_cnt", 64'(err_cnt), 2);
        check("idle_in_ready", 64'(in_ready), 0);

        // Large and negative errors
        exp_q.push_back(res_b());
        do_start();
        send_set(1'b1, no_gaps, 4);
        in_valid = 1'b0;
        wait_done("done_b");
        handshake("hs_b");

        // Bursty input: same result, busy throughout, exactly 4 accepts
        exp_q.push_back(res_a());
        do_start();
        acc_cnt = 0;
        busy_err = 0;
        track_busy = 1'b1;
        send_set(1'b0, burst_gaps, 4);
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        wait_done("done_burst");
        track_busy = 1'b0;
        check("burst_accepts", 64'(acc_cnt), 4);
        check("burst_busy", 64'(busy_err), 0);
        handshake("hs_burst");

        // Abort with clr after two accepts, then a fresh window
        do_start();
        send_set(1'b0, no_gaps, 2);
        in_valid = 1'b0;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_in_ready", 64'(in_ready), 0);
        check("clr_busy", 64'(busy), 0);
        @(negedge clk);
        check("clr_out_valid", 64'(out_valid), 0);
        exp_q.push_back(res_a());
        do_start();
        send_set(1'b0, no_gaps, 4);
        in_valid = 1'b0;
        wait_done("done_after_clr");
        handshake("hs_after_clr");

        // Asynchronous reset mid-window
        do_start();
        send_set(1'b1, no_gaps, 2);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_sum_ed", 64'(sum_ed), 0);
        check("rst_sum_sed", 64'(sum_sed), 0);
        check("rst_max_ed", 64'(max_ed), 0);
        check("rst_err_cnt", 64'(err_cnt), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_in_ready", 64'(in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.push_back(res_b());
        do_start();
        send_set(1'b1, no_gaps, 4);
        in_valid = 1'b0;
        wait_done("done_after_rst");
        handshake("hs_after_rst");
    endtask

    task automatic run_big();
        res_t r;
        int n = 0;
        r.ed = 0; r.sed = 0; r.mx = 0; r.cnt = 0; r.sq = 0;
        exp16_q.push_back(r);
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        for (int i = 0; i < 256; i++) begin
            for (int j = 0; j < 256; j++) begin
                in_valid16 = 1'b1;
                x16 = 8'(i);
                y16 = 8'(j);
                z16 = 16'(i * j);
                @(negedge clk);
            end
        end
        in_valid16 = 1'b0;
        check("sweep_drain_ready", 64'(in_ready16), 0);
        while (!out_valid16 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("sweep_done", 64'(out_valid16), 1);
        out_ready16 = 1'b1;
        @(negedge clk);
        out_ready16 = 1'b0;
        check("sweep_hs", 64'(out_valid16), 0);
    endtask

    initial begin
        #1;
        rst_n = 1'b0;
        rst_n16 = 1'b0;
        #3;
        check("reset_in_ready", 64'(in_ready), 0);
        check("reset_out_valid", 64'(out_valid), 0);
        check("reset_busy", 64'(busy), 0);
        check("reset_sum_ed", 64'(sum_ed), 0);
        check("reset_err_cnt", 64'(err_cnt), 0);
        check("reset16_out_valid", 64'(out_valid16), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rst_n16 = 1'b1;
        @(negedge clk);
        fork
            run_small();
            run_big();
        join
        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 0);
        check("scoreboard16_empty", 64'(exp16_q.size()), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
